// File: rtl/udp_frame_packetizer.sv
// Splits one video frame into UDP payloads framed by the 53 5A 48 59 header.
// Trailing CRC-16/MODBUS covers header and image bytes; works for any frame/payload geometry.
module udp_frame_packetizer #(
  parameter int unsigned H_PIXEL       = 1280,
  parameter int unsigned V_PIXEL       = 720,
  parameter int unsigned BPP           = 2,
  parameter int unsigned PAYLOAD_BYTES = 1280,
  parameter logic [7:0]  DEV_ADDR      = 8'h00,
  parameter logic [7:0]  CMD           = 8'h02,
  parameter int unsigned GAP_CYCLES    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        fifo_ready,
  input  logic [7:0]  pix_data,
  output logic        fifo_rd_en,
  output logic        tx_start,
  output logic [15:0] tx_len,
  input  logic        tx_byte_req,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] pkt_index,
  output logic [2:0]  dbg_state
);
  localparam int unsigned IMG      = H_PIXEL * V_PIXEL * BPP;
  localparam int unsigned NPKT     = (IMG + PAYLOAD_BYTES - 1) / PAYLOAD_BYTES;
  localparam int unsigned LAST_IMG = IMG - (NPKT - 1) * PAYLOAD_BYTES;

  localparam logic [31:0] LEN_FIELD = 32'(IMG + 12);
  localparam logic [15:0] LAST_PKT  = 16'(NPKT - 1);
  localparam logic [15:0] PAY_LEN   = 16'(PAYLOAD_BYTES);
  localparam logic [15:0] LAST_LEN  = 16'(LAST_IMG);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FIFO = 3'd1,
    S_START     = 3'd2,
    S_SEND      = 3'd3,
    S_GAP       = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pkt_q, pkt_d;
  logic [15:0] byte_q, byte_d;
  logic [15:0] len_q, len_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] crc_q, crc_d;
  logic        final_q, final_d;
  logic        frame_done_q, frame_done_d;

  logic        is_first, is_last;
  logic [15:0] hdr_len, img_len, img_end, pkt_len;
  logic        in_range, is_hdr, is_img, is_crc, consume;
  logic [7:0]  hdr_byte;

  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // Packet layout derives from pkt_q, which already names the upcoming packet in WAIT_FIFO.
  assign is_first = (pkt_q == 16'd0);
  assign is_last  = (pkt_q == LAST_PKT);
  assign hdr_len  = is_first ? 16'd10 : 16'd0;
  assign img_len  = is_last ? LAST_LEN : PAY_LEN;
  assign img_end  = hdr_len + img_len;
  assign pkt_len  = img_end + (is_last ? 16'd2 : 16'd0);

  // Handshake: tx_byte_req is a ready strobe from the UDP engine. tx_data is valid for the
  // whole SEND state; a byte transfers on every clock with tx_byte_req high while bytes remain.
  assign in_range   = (state_q == S_SEND) && (byte_q < len_q);
  assign is_hdr     = in_range && (byte_q < hdr_len);
  assign is_img     = in_range && (byte_q >= hdr_len) && (byte_q < img_end);
  assign is_crc     = in_range && (byte_q >= img_end);
  assign consume    = tx_byte_req && in_range;
  assign fifo_rd_en = tx_byte_req && is_img;

  always_comb begin
    case (byte_q[3:0])
      4'd0:    hdr_byte = 8'h53;
      4'd1:    hdr_byte = 8'h5A;
      4'd2:    hdr_byte = 8'h48;
      4'd3:    hdr_byte = 8'h59;
      4'd4:    hdr_byte = DEV_ADDR;
      4'd5:    hdr_byte = LEN_FIELD[7:0];
      4'd6:    hdr_byte = LEN_FIELD[15:8];
      4'd7:    hdr_byte = LEN_FIELD[23:16];
      4'd8:    hdr_byte = LEN_FIELD[31:24];
      default: hdr_byte = CMD;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    if (is_hdr) begin
      tx_data = hdr_byte;
    end else if (is_img) begin
      tx_data = pix_data;
    end else if (is_crc) begin
      tx_data = (byte_q == img_end) ? crc_q[7:0] : crc_q[15:8];
    end
  end

  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    byte_d       = byte_q;
    len_d        = len_q;
    gap_d        = gap_q;
    crc_d        = crc_q;
    final_d      = final_q;
    frame_done_d = 1'b0;

    // The CRC stays frozen while its own bytes are on the wire.
    if (consume) begin
      byte_d = byte_q + 16'd1;
      if (!is_crc) crc_d = crc_byte(crc_q, tx_data);
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_WAIT_FIFO;
          pkt_d   = 16'd0;
          crc_d   = 16'hFFFF;
        end
      end
      S_WAIT_FIFO: begin
        if (fifo_ready) begin
          state_d = S_START;
          len_d   = pkt_len;
          byte_d  = 16'd0;
        end
      end
      S_START: state_d = S_SEND;
      S_SEND: begin
        if (tx_done) begin
          state_d = S_GAP;
          gap_d   = 16'd0;
          final_d = is_last;
          if (!is_last) pkt_d = pkt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = final_q ? S_DONE : S_WAIT_FIFO;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pkt_q        <= 16'd0;
      byte_q       <= 16'd0;
      len_q        <= 16'd0;
      gap_q        <= 16'd0;
      crc_q        <= 16'hFFFF;
      final_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      byte_q       <= byte_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      crc_q        <= crc_d;
      final_q      <= final_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_start   = (state_q == S_START);
  assign tx_len     = len_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign pkt_index  = pkt_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_udp_frame_packetizer.sv
// Directed bench: a 4x3x2 frame in 10-byte payloads (three packets) and a 2x2x1 single-packet frame.
// Every delivered byte is checked against a queue built from header constants, pixel pattern and CRC model.
module tb_udp_frame_packetizer;
  localparam int GAP  = 3;
  localparam int IMG0 = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        frame_start, fifo_ready, tx_byte_req, tx_done;
  logic [7:0]  pix_data, tx_data;
  logic        fifo_rd_en, tx_start, busy, frame_done;
  logic [15:0] tx_len, pkt_index;
  logic [2:0]  dbg_state;

  logic        frame_start1, fifo_ready1, tx_byte_req1, tx_done1;
  logic [7:0]  pix_data1, tx_data1;
  logic        fifo_rd_en1, tx_start1, busy1, frame_done1;
  logic [15:0] tx_len1, pkt_index1;
  logic [2:0]  dbg_state1;

  udp_frame_packetizer #(.H_PIXEL(4), .V_PIXEL(3), .BPP(2), .PAYLOAD_BYTES(10),
                         .DEV_ADDR(8'h00), .CMD(8'h02), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .fifo_ready(fifo_ready),
    .pix_data(pix_data), .fifo_rd_en(fifo_rd_en), .tx_start(tx_start), .tx_len(tx_len),
    .tx_byte_req(tx_byte_req), .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
    .frame_done(frame_done), .pkt_index(pkt_index), .dbg_state(dbg_state));

  udp_frame_packetizer #(.H_PIXEL(2), .V_PIXEL(2), .BPP(1), .PAYLOAD_BYTES(64)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start1), .fifo_ready(fifo_ready1),
    .pix_data(pix_data1), .fifo_rd_en(fifo_rd_en1), .tx_start(tx_start1), .tx_len(tx_len1),
    .tx_byte_req(tx_byte_req1), .tx_data(tx_data1), .tx_done(tx_done1), .busy(busy1),
    .frame_done(frame_done1), .pkt_index(pkt_index1), .dbg_state(dbg_state1));

  // FIFO models: show-ahead data is a function of the read pointer.
  logic        src_clr;
  logic [15:0] ptr0, ptr1;
  always @(posedge clk) begin
    if (src_clr) begin
      ptr0 <= 16'd0;
      ptr1 <= 16'd0;
    end else begin
      if (fifo_rd_en)  ptr0 <= ptr0 + 16'd1;
      if (fifo_rd_en1) ptr1 <= ptr1 + 16'd1;
    end
  end
  assign pix_data  = 8'(ptr0) ^ 8'h5C;
  assign pix_data1 = 8'(ptr1 + 16'd1);

  int cyc = 0;
  int fd_cnt0 = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_done) fd_cnt0 <= fd_cnt0 + 1;
  end

  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int done_cyc = 0;

  typedef struct {
    int          ready_delay;
    int          req_gap;
    int          extra_req;
    bit          done_same;
    bit          poke_start;
    logic [15:0] exp_len;
    logic [15:0] exp_pkt;
  } pkt_vec_t;
  pkt_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic load_stream(input logic [7:0] len_lo, input int img, input bit dut1);
    logic [7:0]  hdr[10];
    logic [7:0]  b;
    logic [15:0] c;
    hdr = '{8'h53, 8'h5A, 8'h48, 8'h59, 8'h00, len_lo, 8'h00, 8'h00, 8'h00, 8'h02};
    exp_q.delete();
    c = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(hdr[i]);
      c = crc16(c, hdr[i]);
    end
    for (int i = 0; i < img; i++) begin
      b = dut1 ? 8'(i + 1) : (8'(i) ^ 8'h5C);
      exp_q.push_back(b);
      c = crc16(c, b);
    end
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic next_exp(output logic [7:0] b);
    if (exp_q.size() == 0) b = 8'hxx;
    else b = exp_q.pop_front();
  endtask

  task automatic start_frame0();
    load_stream(8'h24, IMG0, 1'b0);
    fifo_ready = 1'b1;
    @(negedge clk); src_clr = 1'b1;
    @(negedge clk); src_clr = 1'b0; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    #1 check("busy_after_start", busy, 1);
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk); #1;
      seen = tx_start;
    end
    check("tx_start_seen", seen, 1);
  endtask

  task automatic run_packet(input pkt_vec_t v, input bit first);
    int         starts;
    bit         seen;
    logic [7:0] b;
    if (v.ready_delay > 0) begin
      fifo_ready = 1'b0;
      starts = 0;
      repeat (v.ready_delay) begin
        @(negedge clk); #1;
        if (tx_start) starts++;
      end
      check("start_while_fifo_not_ready", starts, 0);
      fifo_ready = 1'b1;
    end
    wait_start(seen);
    check("tx_len", tx_len, v.exp_len);
    check("pkt_index_at_start", pkt_index, v.exp_pkt);
    if (!first) check("gap_honoured", (cyc - done_cyc) > GAP, 1);
    for (int i = 0; i < int'(v.exp_len); i++) begin
      @(negedge clk);
      tx_byte_req = 1'b0;
      frame_start = 1'b0;
      repeat ($urandom_range(v.req_gap, 0)) @(negedge clk);
      tx_byte_req = 1'b1;
      if (v.poke_start && i == 2) frame_start = 1'b1;
      if (v.done_same && i == int'(v.exp_len) - 1) begin
        tx_done = 1'b1;
        done_cyc = cyc;
      end
      #1 next_exp(b);
      check("tx_data", tx_data, b);
    end
    for (int i = 0; i < v.extra_req; i++) begin
      @(negedge clk);
      tx_byte_req = 1'b1;
      #1 check("extra_req_data_zero", tx_data, 0);
      check("extra_req_no_pop", fifo_rd_en, 0);
    end
    @(negedge clk);
    tx_byte_req = 1'b0;
    frame_start = 1'b0;
    if (v.done_same) begin
      tx_done = 1'b0;
    end else begin
      tx_done = 1'b1;
      done_cyc = cyc;
      @(negedge clk);
      tx_done = 1'b0;
    end
    if (v.poke_start) begin
      #1 check("pkt_index_after_poke", pkt_index, v.exp_pkt + 16'd1);
      check("busy_after_poke", busy, 1);
    end
  endtask

  task automatic run_frame(input int base);
    int fd0;
    bit got;
    start_frame0();
    fd0 = fd_cnt0;
    for (int k = 0; k < 3; k++) run_packet(vecs[base + k], k == 0);
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk); #1;
      got = frame_done;
    end
    check("frame_done_seen", got, 1);
    check("busy_low_at_frame_done", busy, 0);
    @(negedge clk); @(negedge clk);
    check("frame_done_count", fd_cnt0 - fd0, 1);
    check("pop_count", ptr0, IMG0);
    check("stream_drained", exp_q.size(), 0);
    check("pkt_index_final", pkt_index, 2);
  endtask

  initial begin
    bit         seen;
    logic [7:0] b;
    frame_start = 1'b0; fifo_ready = 1'b0; tx_byte_req = 1'b0; tx_done = 1'b0;
    frame_start1 = 1'b0; fifo_ready1 = 1'b0; tx_byte_req1 = 1'b0; tx_done1 = 1'b0;
    src_clr = 1'b1;

    // ready_delay, req_gap, extra_req, done_same, poke_start, exp_len, exp_pkt
    vecs[0] = '{0,  0, 0, 1'b0, 1'b0, 16'd20, 16'd0};
    vecs[1] = '{0,  0, 0, 1'b0, 1'b0, 16'd10, 16'd1};
    vecs[2] = '{0,  0, 0, 1'b0, 1'b0, 16'd6,  16'd2};
    vecs[3] = '{0,  3, 2, 1'b0, 1'b0, 16'd20, 16'd0};
    vecs[4] = '{50, 2, 0, 1'b1, 1'b1, 16'd10, 16'd1};
    vecs[5] = '{0,  3, 1, 1'b0, 1'b0, 16'd6,  16'd2};

    repeat (3) @(negedge clk);
    #1 check("rst_busy", busy, 0);
    check("rst_tx_len", tx_len, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_pkt_index", pkt_index, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    src_clr = 1'b0;

    run_frame(0);
    run_frame(3);

    // Reset in the middle of packet 1 while the sink is still requesting.
    start_frame0();
    run_packet(vecs[0], 1'b1);
    wait_start(seen);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_byte_req = 1'b1;
      #1 next_exp(b);
      check("tx_data_pre_reset", tx_data, b);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("mid_rst_fifo_rd_en", fifo_rd_en, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_len", tx_len, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_pkt_index", pkt_index, 0);
    check("mid_rst_state", dbg_state, 0);
    tx_byte_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0);

    // Single-packet frame: header, pixels 01..04, CRC.
    load_stream(8'h10, 4, 1'b1);
    fifo_ready1 = 1'b1;
    @(negedge clk); src_clr = 1'b1;
    @(negedge clk); src_clr = 1'b0; frame_start1 = 1'b1;
    @(negedge clk); frame_start1 = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk); #1;
      seen = tx_start1;
    end
    check("single_tx_start_seen", seen, 1);
    check("single_tx_len", tx_len1, 16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tx_byte_req1 = 1'b1;
      #1 next_exp(b);
      check("single_tx_data", tx_data1, b);
    end
    @(negedge clk);
    tx_byte_req1 = 1'b0;
    tx_done1 = 1'b1;
    @(negedge clk);
    tx_done1 = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk); #1;
      seen = frame_done1;
    end
    check("single_frame_done", seen, 1);
    check("single_pop_count", ptr1, 4);
    check("single_pkt_index", pkt_index1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
